// File: rtl/serial_adder_subtractor.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB slice first.
// Results, carry and overflow are committed together when the last slice completes.
module serial_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ctrl,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nx;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [DIGIT-1:0] a_sl, b_sl, s_sl;
  logic [DIGIT:0]   slice_sum;
  logic             c_out, c_msb;
  logic             load, last;

  assign a_sl      = a_q[DIGIT-1:0];
  assign b_sl      = b_q[DIGIT-1:0];
  assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl}
                   + (DIGIT+1)'(carry_q);
  assign s_sl      = slice_sum[DIGIT-1:0];
  assign c_out     = slice_sum[DIGIT];
  // carry into the top bit of this slice; meaningful on the final slice
  assign c_msb     = s_sl[DIGIT-1] ^ a_sl[DIGIT-1]
                   ^ b_sl[DIGIT-1];
  assign sum_nx    = WIDTH'({s_sl, sum_q} >> DIGIT);

  assign last = (cnt_q == LAST);
  assign load = i_start
              && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = i_start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (state_q)
      RUN:     o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      o_result    <= '0;
      o_carry_out <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (load) begin
      a_q     <= i_a;
      b_q     <= i_ctrl ? ~i_b : i_b;
      carry_q <= i_ctrl;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= c_out;
      sum_q   <= sum_nx;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        o_result    <= sum_nx;
        o_carry_out <= c_out;
        o_overflow  <= c_msb ^ c_out;
      end
    end
  end

endmodule
